// File: rtl/command_header_parser.sv
// Front end of the management module: parses the 10-byte TPM command header from the host FIFO,
// captures up to four parameter bytes, checks framing and issues the command with a keyStart_n strobe.
module command_header_parser #(
    parameter int MAX_CMD_SIZE = 4096,
    parameter int START_PULSE  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [7:0]  in_locality,
    output logic [31:0] tpm_cc,
    output logic [32:0] cmd_param,
    output logic [15:0] cmd_tag,
    output logic [31:0] cmd_size,
    output logic [7:0]  locality,
    output logic        keyStart_n,
    output logic [31:0] hdr_rc,
    output logic        hdr_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PARAM,
        DRAIN,
        FLUSH,
        ISSUE,
        ERR
    } state_t;

    localparam int          PULSE_LEN   = (START_PULSE < 1) ? 1 : ((START_PULSE > 15) ? 15 : START_PULSE);
    localparam logic [3:0]  PULSE_LAST  = 4'(PULSE_LEN - 1);
    localparam logic [31:0] MAX_SIZE    = 32'(MAX_CMD_SIZE);
    localparam logic [31:0] MIN_SIZE    = 32'd10;
    localparam logic [31:0] RC_BAD_TAG  = 32'h0000_001E;
    localparam logic [31:0] RC_CMD_SIZE = 32'h0000_0142;

    state_t      state;
    state_t      stateNext;
    logic [31:0] byteCnt;
    logic [31:0] cntNext;
    logic [31:0] cntInc;
    logic [15:0] tagSh;
    logic [15:0] tagNext;
    logic [31:0] sizeSh;
    logic [31:0] sizeNext;
    logic [31:0] ccSh;
    logic [31:0] ccNext;
    logic [32:0] paramSh;
    logic [32:0] paramNext;
    logic [7:0]  locSh;
    logic [7:0]  locNext;
    logic        lastSeen;
    logic        lastNext;
    logic [3:0]  pulseCnt;
    logic [31:0] rcLoad;
    logic        accept;
    logic        tagOk;
    logic        sizeBad;
    logic        issueEntry;

    function automatic logic isReceiving(input state_t s);
        return (s == IDLE) || (s == HDR) || (s == PARAM) || (s == DRAIN) || (s == FLUSH);
    endfunction

    assign accept     = in_valid && in_ready;
    assign cntInc     = byteCnt + 32'd1;
    assign tagOk      = (tagSh == 16'h8001) || (tagSh == 16'h8002);
    assign sizeBad    = (sizeSh < MIN_SIZE) || (sizeSh > MAX_SIZE);
    assign issueEntry = (stateNext == ISSUE) && (state != ISSUE);

    always_comb begin
        stateNext = state;
        cntNext   = byteCnt;
        tagNext   = tagSh;
        sizeNext  = sizeSh;
        ccNext    = ccSh;
        paramNext = paramSh;
        locNext   = locSh;
        lastNext  = lastSeen;
        rcLoad    = 32'd0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    tagNext   = {in_data, 8'h00};
                    cntNext   = 32'd1;
                    locNext   = in_locality;
                    paramNext = '0;
                    lastNext  = in_last;
                    if (in_last) begin
                        rcLoad    = RC_CMD_SIZE;
                        stateNext = ERR;
                    end else begin
                        stateNext = HDR;
                    end
                end
            end

            HDR: begin
                if (accept) begin
                    cntNext  = cntInc;
                    lastNext = in_last;
                    if (byteCnt == 32'd1) begin
                        tagNext = {tagSh[15:8], in_data};
                    end else if (byteCnt <= 32'd5) begin
                        sizeNext = {sizeSh[23:0], in_data};
                    end else begin
                        ccNext = {ccSh[23:0], in_data};
                    end
                    // Tag and size are complete in the shadows by the time byte 9 arrives
                    if (byteCnt == 32'd9) begin
                        if (!tagOk) begin
                            rcLoad    = RC_BAD_TAG;
                            stateNext = ERR;
                        end else if (sizeBad) begin
                            rcLoad    = RC_CMD_SIZE;
                            stateNext = ERR;
                        end else if (sizeSh == MIN_SIZE) begin
                            if (in_last) begin
                                stateNext = ISSUE;
                            end else begin
                                rcLoad    = RC_CMD_SIZE;
                                stateNext = ERR;
                            end
                        end else if (in_last) begin
                            rcLoad    = RC_CMD_SIZE;
                            stateNext = ERR;
                        end else begin
                            stateNext = PARAM;
                        end
                    end else if (in_last) begin
                        rcLoad    = RC_CMD_SIZE;
                        stateNext = ERR;
                    end
                end
            end

            PARAM, DRAIN: begin
                if (accept) begin
                    cntNext  = cntInc;
                    lastNext = in_last;
                    if (state == PARAM) begin
                        paramNext = {1'b1, paramSh[23:0], in_data};
                    end
                    if (cntInc == sizeSh) begin
                        if (in_last) begin
                            stateNext = ISSUE;
                        end else begin
                            rcLoad    = RC_CMD_SIZE;
                            stateNext = ERR;
                        end
                    end else if (in_last) begin
                        rcLoad    = RC_CMD_SIZE;
                        stateNext = ERR;
                    end else if ((state == PARAM) && (byteCnt == 32'd13)) begin
                        stateNext = DRAIN;
                    end
                end
            end

            FLUSH: begin
                if (accept && in_last) begin
                    stateNext = IDLE;
                end
            end

            ISSUE: begin
                if (pulseCnt == 4'd0) begin
                    stateNext = IDLE;
                end
            end

            ERR: begin
                stateNext = lastSeen ? IDLE : FLUSH;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            byteCnt  <= 32'd0;
            lastSeen <= 1'b0;
            pulseCnt <= 4'd0;
        end else begin
            state    <= stateNext;
            byteCnt  <= cntNext;
            lastSeen <= lastNext;
            pulseCnt <= (state == ISSUE) ? pulseCnt - 4'd1 : PULSE_LAST;
        end
    end

    always_ff @(posedge clock) begin
        tagSh   <= tagNext;
        sizeSh  <= sizeNext;
        ccSh    <= ccNext;
        paramSh <= paramNext;
        locSh   <= locNext;
    end

    // Outputs load on entry to ISSUE from the next-shadow values so they are valid with the strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready   <= 1'b0;
            keyStart_n <= 1'b1;
            hdr_err    <= 1'b0;
            hdr_rc     <= 32'd0;
            tpm_cc     <= 32'd0;
            cmd_param  <= 33'd0;
            cmd_tag    <= 16'd0;
            cmd_size   <= 32'd0;
            locality   <= 8'd0;
        end else begin
            in_ready   <= isReceiving(stateNext);
            keyStart_n <= (stateNext != ISSUE);
            hdr_err    <= (stateNext == ERR);
            if (stateNext == ERR) begin
                hdr_rc <= rcLoad;
            end
            if (issueEntry) begin
                hdr_rc    <= 32'd0;
                tpm_cc    <= ccNext;
                cmd_param <= paramNext;
                cmd_tag   <= tagNext;
                cmd_size  <= sizeNext;
                locality  <= locNext;
            end
        end
    end

endmodule

// File: tb/tb_command_header_parser.sv
// Bench for command_header_parser: table of command transfers, each pushing its expected strobe or
// error event to a queue that a negedge monitor pops and compares against the DUT outputs.
module tb_command_header_parser;

    localparam int PULSE = 1;
    localparam int NV    = 14;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  in_locality;
    logic [31:0] tpm_cc;
    logic [32:0] cmd_param;
    logic [15:0] cmd_tag;
    logic [31:0] cmd_size;
    logic [7:0]  locality;
    logic        keyStart_n;
    logic [31:0] hdr_rc;
    logic        hdr_err;

    command_header_parser #(
        .MAX_CMD_SIZE(4096),
        .START_PULSE (PULSE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .in_locality(in_locality),
        .tpm_cc     (tpm_cc),
        .cmd_param  (cmd_param),
        .cmd_tag    (cmd_tag),
        .cmd_size   (cmd_size),
        .locality   (locality),
        .keyStart_n (keyStart_n),
        .hdr_rc     (hdr_rc),
        .hdr_err    (hdr_err)
    );

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] size;
        logic [31:0] cc;
        logic [79:0] params;
        int          len;
        logic        gaps;
        logic [7:0]  loc;
        logic        expIssue;
        logic [31:0] expRc;
        logic [32:0] expParam;
    } vec_t;

    typedef struct packed {
        logic        isIssue;
        logic [31:0] cc;
        logic [32:0] param;
        logic [15:0] tag;
        logic [31:0] size;
        logic [7:0]  loc;
        logic [31:0] rc;
    } exp_t;

    exp_t        expQ[$];
    vec_t        vecs[NV];
    vec_t        clearVec;
    int          nChecks = 0;
    int          nFails  = 0;
    int          lowLen  = 0;
    logic [31:0] mCc;
    logic [32:0] mParam;
    logic [15:0] mTag;
    logic [31:0] mSize;
    logic [7:0]  mLoc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compareEvent(input logic isIssue);
        exp_t e;
        if (expQ.size() == 0) begin
            check(isIssue ? "unexpected_strobe" : "unexpected_hdr_err", 64'd1, 64'd0);
            return;
        end
        e = expQ.pop_front();
        check("event_kind", 64'(isIssue), 64'(e.isIssue));
        check("tpm_cc", 64'(tpm_cc), 64'(e.cc));
        check("cmd_param", 64'(cmd_param), 64'(e.param));
        check("cmd_tag", 64'(cmd_tag), 64'(e.tag));
        check("cmd_size", 64'(cmd_size), 64'(e.size));
        check("locality", 64'(locality), 64'(e.loc));
        check("hdr_rc", 64'(hdr_rc), 64'(e.rc));
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            lowLen = 0;
        end else begin
            if (!keyStart_n) begin
                if (lowLen == 0) compareEvent(1'b1);
                lowLen++;
            end else if (lowLen != 0) begin
                check("strobe_len", 64'(lowLen), 64'(PULSE));
                lowLen = 0;
            end
            if (hdr_err) compareEvent(1'b0);
        end
    end

    task automatic pushExpected(input vec_t v);
        exp_t e;
        if (v.expIssue) begin
            mCc = v.cc; mParam = v.expParam; mTag = v.tag; mSize = v.size; mLoc = v.loc;
        end
        e.isIssue = v.expIssue;
        e.cc      = mCc;
        e.param   = mParam;
        e.tag     = mTag;
        e.size    = mSize;
        e.loc     = mLoc;
        e.rc      = v.expRc;
        expQ.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred
    task automatic sendByte(input logic [7:0] d, input logic last);
        int waitCnt;
        waitCnt  = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 200) begin
            @(negedge clock);
            waitCnt++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendCmd(input vec_t v);
        logic [79:0] hdr;
        logic [7:0]  b;
        int          pidx;
        hdr = {v.tag, v.size, v.cc};
        in_locality = v.loc;
        for (int i = 0; i < v.len; i++) begin
            if (v.gaps && i > 0) repeat ((i % 3) + 1) @(negedge clock);
            if (i < 10) begin
                b = hdr[79 - 8 * i -: 8];
            end else begin
                pidx = i - 10;
                b = (pidx < 10) ? v.params[79 - 8 * pidx -: 8] : 8'(pidx);
            end
            sendByte(b, (i == v.len - 1));
        end
        repeat (PULSE + 4) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            tag       size        cc          params                     len   gap   loc    iss   rc          param
        vecs[0]  = '{16'h8001, 32'd12,     32'h144, {16'h0001, 64'h0},          12,   1'b0, 8'h03, 1'b1, 32'h0,      33'h1_00000001};
        vecs[1]  = '{16'h8001, 32'd11,     32'h143, {8'h01, 72'h0},             11,   1'b1, 8'h00, 1'b1, 32'h0,      33'h1_00000001};
        vecs[2]  = '{16'h8003, 32'd12,     32'h17A, 80'h0,                      12,   1'b0, 8'h02, 1'b0, 32'h01E,    33'h0};
        vecs[3]  = '{16'h8001, 32'd8,      32'h144, {40'hAABBCCDDEE, 40'h0},    15,   1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[4]  = '{16'h8001, 32'd12,     32'h17B, {16'h0008, 64'h0},          12,   1'b0, 8'h01, 1'b1, 32'h0,      33'h1_00000008};
        vecs[5]  = '{16'h8001, 32'd12,     32'h144, 80'h0,                      7,    1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[6]  = '{16'h8002, 32'd20,     32'h15D, 80'h4000000C010203040506,   20,   1'b1, 8'h04, 1'b1, 32'h0,      33'h1_4000000C};
        vecs[7]  = '{16'h8001, 32'd10,     32'h145, 80'h0,                      10,   1'b0, 8'h00, 1'b1, 32'h0,      33'h0};
        vecs[8]  = '{16'h8001, 32'd10,     32'h145, {16'h1122, 64'h0},          12,   1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[9]  = '{16'h8001, 32'h1001,   32'h144, 80'h0,                      12,   1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[10] = '{16'h8001, 32'd12,     32'h144, 80'h0,                      1,    1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[11] = '{16'h8002, 32'd14,     32'h17B, {32'h01020304, 48'h0},      14,   1'b0, 8'h02, 1'b1, 32'h0,      33'h1_01020304};
        vecs[12] = '{16'h8001, 32'd12,     32'h144, 80'h0,                      14,   1'b0, 8'h00, 1'b0, 32'h142,    33'h0};
        vecs[13] = '{16'h8001, 32'd4096,   32'h17B, 80'h00010203040506070809,   4096, 1'b0, 8'h05, 1'b1, 32'h0,      33'h1_00010203};
        clearVec = '{16'h8001, 32'd12,     32'h144, 80'h0,                      12,   1'b0, 8'h00, 1'b1, 32'h0,      33'h1_00000000};

        mCc = '0; mParam = '0; mTag = '0; mSize = '0; mLoc = '0;
        reset_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_locality = '0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_keyStart_n", 64'(keyStart_n), 64'd1);
        check("rst_tpm_cc", 64'(tpm_cc), 64'd0);
        check("rst_hdr_rc", 64'(hdr_rc), 64'd0);
        check("rst_hdr_err", 64'(hdr_err), 64'd0);
        reset_n = 1'b1;
        #1 check("in_ready_before_first_clk", 64'(in_ready), 64'd0);
        @(negedge clock);
        check("in_ready_after_first_clk", 64'(in_ready), 64'd1);

        for (int v = 0; v < NV; v++) begin
            pushExpected(vecs[v]);
            sendCmd(vecs[v]);
            check("event_consumed", 64'(expQ.size()), 64'd0);
        end

        // Reset in the middle of header byte 4 discards the command silently
        in_locality = 8'h07;
        sendByte(8'h80, 1'b0);
        sendByte(8'h01, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        in_data = 8'h00; in_valid = 1'b1; in_last = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_keyStart_n", 64'(keyStart_n), 64'd1);
        check("midrst_tpm_cc", 64'(tpm_cc), 64'd0);
        check("midrst_cmd_param", 64'(cmd_param), 64'd0);
        check("midrst_cmd_size", 64'(cmd_size), 64'd0);
        check("midrst_locality", 64'(locality), 64'd0);
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mCc = '0; mParam = '0; mTag = '0; mSize = '0; mLoc = '0;
        @(negedge clock);
        check("in_ready_after_midrst", 64'(in_ready), 64'd1);
        pushExpected(clearVec);
        sendCmd(clearVec);
        check("events_pending", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
